pdec_upm_seq: RTL and testbench

PDEC_UPM_SEQ -- requirements
Module: pdec_upm_seq

---
 rtl/pdec_upm_seq.sv | 177 +++++++++++++++++
 tb/tb_pdec_upm_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pdec_upm_seq.sv
// Node-command sequencer for the path-metric update unit and the path sorter.
// Optional watchdog enabled by defining PDEC_UPM_WDOG_EN (adds err_timeout).
module pdec_upm_seq #(
   parameter int unsigned NUM_PATH = 8,
   parameter int unsigned WID_BEAT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_start,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_jump_type,
   input  logic [WID_BEAT-1:0] cmd_beats,
   input  logic [NUM_PATH-1:0] cmd_path_mask,
   output logic [NUM_PATH-1:0] upm_llr_st,
   output logic [NUM_PATH-1:0] upm_llr_en,
   output logic [1:0]          upm_pm_src_ind,
   input  logic                upm_done,
   output logic                srt_req,
   input  logic                srt_done,
   output logic                seq_done,
`ifdef PDEC_UPM_WDOG_EN
   output logic                seq_busy,
   output logic                err_timeout
`else
   output logic                seq_busy
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_FEED, S_WAIT_UPM, S_SORT_REQ, S_SORT_WAIT, S_DONE
   } state_t;

   state_t              state;
   logic [2:0]          jt_q;
   logic [WID_BEAT-1:0] beats_q;
   logic [NUM_PATH-1:0] mask_q;
   logic [WID_BEAT-1:0] cnt;
   logic                upm_seen;
   logic [1:0]          src_q;
   logic [NUM_PATH-1:0] llr_st_q;
   logic [NUM_PATH-1:0] llr_en_q;
   logic                srt_req_q;
   logic                seq_done_q;
   logic                jt_info;
`ifdef PDEC_UPM_WDOG_EN
   logic [7:0]          wd_cnt;
   logic                err_q;
`endif

   assign jt_info        = (jt_q >= 3'd2) && (jt_q <= 3'd5);
   assign cmd_ready      = (state == S_IDLE);
   assign seq_busy       = (state != S_IDLE);
   assign upm_llr_st     = llr_st_q;
   assign upm_llr_en     = llr_en_q;
   assign upm_pm_src_ind = src_q;
   assign srt_req        = srt_req_q;
   assign seq_done       = seq_done_q;
`ifdef PDEC_UPM_WDOG_EN
   assign err_timeout    = err_q;
`endif

   // Strobes are pulses: cleared every cycle unless the transition below re-arms them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         jt_q       <= '0;
         beats_q    <= '0;
         mask_q     <= '0;
         cnt        <= '0;
         upm_seen   <= 1'b0;
         src_q      <= '0;
         llr_st_q   <= '0;
         llr_en_q   <= '0;
         srt_req_q  <= 1'b0;
         seq_done_q <= 1'b0;
`ifdef PDEC_UPM_WDOG_EN
         wd_cnt     <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         llr_st_q   <= '0;
         llr_en_q   <= '0;
         srt_req_q  <= 1'b0;
         seq_done_q <= 1'b0;
`ifdef PDEC_UPM_WDOG_EN
         wd_cnt     <= '0;
`endif
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  jt_q    <= cmd_jump_type;
                  beats_q <= cmd_beats;
                  mask_q  <= cmd_path_mask;
                  if (cmd_jump_type[2:1] == 2'b11) begin
                     state      <= S_DONE;
                     seq_done_q <= 1'b1;
                  end else begin
                     state    <= S_START;
                     llr_st_q <= cmd_path_mask;
                  end
               end
            end
            S_START: begin
               state    <= S_FEED;
               llr_en_q <= mask_q;
               cnt      <= (beats_q == '0) ? '0 : beats_q - 1'b1;
               if (upm_done) upm_seen <= 1'b1;
            end
            S_FEED: begin
               if (upm_done) upm_seen <= 1'b1;
               if (cnt == '0) begin
                  state <= S_WAIT_UPM;
               end else begin
                  cnt      <= cnt - 1'b1;
                  llr_en_q <= mask_q;
               end
            end
            S_WAIT_UPM: begin
               if (upm_seen || upm_done) begin
                  if (jt_info) begin
                     state     <= S_SORT_REQ;
                     srt_req_q <= 1'b1;
                  end else begin
                     state      <= S_DONE;
                     seq_done_q <= 1'b1;
                  end
`ifdef PDEC_UPM_WDOG_EN
               end else if (wd_cnt == 8'd254) begin
                  err_q      <= 1'b1;
                  state      <= S_DONE;
                  seq_done_q <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
`endif
               end
            end
            S_SORT_REQ: begin
               if (srt_done) begin
                  state      <= S_DONE;
                  seq_done_q <= 1'b1;
               end else begin
                  state <= S_SORT_WAIT;
               end
            end
            S_SORT_WAIT: begin
               if (srt_done) begin
                  state      <= S_DONE;
                  seq_done_q <= 1'b1;
`ifdef PDEC_UPM_WDOG_EN
               end else if (wd_cnt == 8'd254) begin
                  err_q      <= 1'b1;
                  state      <= S_DONE;
                  seq_done_q <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
`endif
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               upm_seen <= 1'b0;
               if (jt_q[2:1] != 2'b11) src_q <= jt_info ? 2'd2 : 2'd1;
            end
            default: state <= S_IDLE;
         endcase
         // Placed last so a coinciding DONE update loses to frame_start.
         if (frame_start) begin
            src_q <= '0;
`ifdef PDEC_UPM_WDOG_EN
            err_q <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_pdec_upm_seq.sv
// Randomized bench for pdec_upm_seq against a per-command timeline model.
// Define PDEC_UPM_WDOG_EN to also exercise the watchdog.
module tb_pdec_upm_seq;
   localparam int unsigned NP = 8;
   localparam int unsigned WB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_start = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          upm_done = 1'b0;
   logic          srt_done = 1'b0;
   logic [2:0]    cmd_jump_type = '0;
   logic [WB-1:0] cmd_beats = '0;
   logic [NP-1:0] cmd_path_mask = '0;
   logic          cmd_ready, srt_req, seq_done, seq_busy;
   logic [NP-1:0] upm_llr_st, upm_llr_en;
   logic [1:0]    upm_pm_src_ind;
`ifdef PDEC_UPM_WDOG_EN
   logic          err_timeout;
   logic          err_m = 1'b0;
`endif

   int total = 0;
   int bad = 0;
   int ncmd = 0;
   logic [1:0] src_m = 2'd0;

   always #5 clk = ~clk;

   pdec_upm_seq #(.NUM_PATH(NP), .WID_BEAT(WB)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_jump_type(cmd_jump_type),
      .cmd_beats(cmd_beats), .cmd_path_mask(cmd_path_mask),
      .upm_llr_st(upm_llr_st), .upm_llr_en(upm_llr_en), .upm_pm_src_ind(upm_pm_src_ind),
      .upm_done(upm_done), .srt_req(srt_req), .srt_done(srt_done),
      .seq_done(seq_done),
`ifdef PDEC_UPM_WDOG_EN
      .seq_busy(seq_busy), .err_timeout(err_timeout)
`else
      .seq_busy(seq_busy)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {10'd0, upm_llr_st, upm_llr_en, srt_req, seq_done, seq_busy, cmd_ready, upm_pm_src_ind};
   endfunction

   function automatic logic [31:0] pack(logic [NP-1:0] st, logic [NP-1:0] en, logic sr,
                                        logic dn, logic bz, logic rd, logic [1:0] src);
      return {10'd0, st, en, sr, dn, bz, rd, src};
   endfunction

   // One command: u = cycle of the upm_done pulse (cycle 0 = START), sd = srt_done
   // delay after leaving WAIT_UPM, fs = frame_start during DONE, ip = stray pulses in IDLE.
   task automatic run_cmd(input int t, input int beats, input int mask, input int u,
                          input int sd, input bit fs, input bit ip);
      int b, w, s, d;
      bit nop, info, to;
      logic [NP-1:0] m;
      logic [1:0] src_new;
      logic [NP-1:0] e_st, e_en;
      logic [1:0] e_src;
      m = NP'(mask);
      b = (beats == 0) ? 1 : beats;
      nop = (t >= 6);
      info = (t >= 2) && (t <= 5);
      to = 1'b0;
      s = -1;
      w = 0;
      if (nop) begin
         d = 0;
      end else begin
         w = (u <= b + 1) ? b + 1 : u;
`ifdef PDEC_UPM_WDOG_EN
         if (u > b + 255) begin
            to = 1'b1;
            w = b + 255;
         end
`endif
         if (info && !to) begin
            s = w + sd;
            d = s + 1;
         end else begin
            d = w + 1;
         end
      end
      src_new = fs ? 2'd0 : nop ? src_m : info ? 2'd2 : 2'd1;
      ncmd++;

      cmd_valid = 1'b1;
      cmd_jump_type = 3'(t);
      cmd_beats = WB'(beats);
      cmd_path_mask = m;
      upm_done = 1'b0;
      srt_done = 1'b0;
      frame_start = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 0; c <= d + 1; c++) begin
         e_st = (!nop && c == 0) ? m : '0;
         e_en = (!nop && c >= 1 && c <= b) ? m : '0;
         e_src = (c <= d) ? src_m : src_new;
         chk($sformatf("cmd%0d_t%0d_c%0d", ncmd, t, c), outs(),
             pack(e_st, e_en, info && !to && c == w + 1, c == d, c <= d, c > d, e_src));
`ifdef PDEC_UPM_WDOG_EN
         chk($sformatf("cmd%0d_err_c%0d", ncmd, c), 32'(err_timeout),
             32'((c < d) ? err_m : (c == d) ? (err_m | to) : (fs ? 1'b0 : (err_m | to))));
`endif
         upm_done = (c == u) || (ip && c == d + 1);
         srt_done = (info && c == s) || (ip && c == d + 1);
         frame_start = fs && (c == d);
         @(negedge clk);
      end
      upm_done = 1'b0;
      srt_done = 1'b0;
      frame_start = 1'b0;
      src_m = src_new;
`ifdef PDEC_UPM_WDOG_EN
      err_m = fs ? 1'b0 : (err_m | to);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=hang exp=finish");
      $fatal(1);
   end

   initial begin
      int t, bt, mk, b, u;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_outs", outs(), pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases.
      run_cmd(0, 3, 'hFF, 5, 1, 1'b0, 1'b0);
      run_cmd(3, 0, 'h0F, 2, 2, 1'b0, 1'b0);
      run_cmd(1, 4, 'hAA, 4, 1, 1'b0, 1'b0);
      run_cmd(4, 2, 'h33, 3, 1, 1'b1, 1'b0);
      run_cmd(0, 1, 'h81, 3, 1, 1'b0, 1'b1);
      run_cmd(6, 5, 'h5A, 0, 1, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         t  = int'($urandom_range(0, 7));
         bt = int'($urandom_range(0, 15));
         mk = int'($urandom_range(0, 255));
         b  = (bt == 0) ? 1 : bt;
         u  = int'($urandom_range(0, b + 3));
         run_cmd(t, bt, mk, u, int'($urandom_range(1, 4)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      end

`ifdef PDEC_UPM_WDOG_EN
      run_cmd(2, 1, 'hC3, 100000, 1, 1'b0, 1'b0);
      run_cmd(0, 2, 'h11, 2, 1, 1'b1, 1'b0);
`endif

      // Mid-operation reset during FEED.
      cmd_valid = 1'b1;
      cmd_jump_type = 3'd2;
      cmd_beats = 4'd5;
      cmd_path_mask = 8'h3C;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_feed_en", 32'(upm_llr_en), 32'h3C);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outs", outs(), pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
      @(negedge clk);
      rst_n = 1'b1;
      src_m = 2'd0;
`ifdef PDEC_UPM_WDOG_EN
      err_m = 1'b0;
`endif
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("post_reset_c%0d", c), outs(),
             pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
         @(negedge clk);
      end
      run_cmd(5, 1, 'hF0, 1, 3, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
